// File: rtl/sdram8_arbiter.sv
// Three-port arbiter in front of the 8-bit SDRAM controller: fixed 8-cycle
// access/refresh slots, port 0 strict priority, ports 1/2 round-robin.
module sdram8_arbiter #(
  parameter int unsigned REFRESH_CYCLES = 499
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [22:0] p0_addr,
  input  logic [7:0]  p0_din,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [22:0] p1_addr,
  input  logic [7:0]  p1_din,
  input  logic        p2_req,
  input  logic        p2_we,
  input  logic [22:0] p2_addr,
  input  logic [7:0]  p2_din,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        p2_ack,
  output logic [7:0]  rdata,
  input  logic        sd_ready,
  output logic        sd_cs,
  output logic        sd_we,
  output logic [22:0] sd_addr,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout,
  output logic        sd_refresh,
  output logic        missed_refresh
);

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 10;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] T6   = CW'(6);
  localparam logic [CW-1:0] LAST = CW'(7);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_GUARD,
    S_IDLE,
    S_ACCESS,
    S_REFRESH
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      port_q;
  logic            rr_q;        // 0: port 1 preferred, 1: port 2 preferred
  logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
  logic            ref_pend_q, ref_pend_d;
  logic            missed_q, missed_d;
  logic [2:0]      ack_q;
  logic [DW-1:0]   rdata_q;
  logic            sd_cs_q;
  logic            sd_we_q;
  logic [AW-1:0]   sd_addr_q;
  logic [DW-1:0]   sd_din_q;
  logic            sd_refresh_q;

  logic            ref_run, ref_expire, grant_ref;
  logic            p1_wins, grant_acc;
  logic [1:0]      grant_port;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_din;

  // Refresh interval timer; frozen while the controller is (re)initialising.
  always_comb begin
    ref_run    = (state_q == S_IDLE) || (state_q == S_ACCESS) || (state_q == S_REFRESH);
    ref_expire = ref_run && (ref_cnt_q == REF_LAST);
    grant_ref  = (state_q == S_IDLE) && sd_ready && (ref_pend_q || ref_expire);
    ref_cnt_d  = ref_cnt_q;
    if (ref_expire) begin
      ref_cnt_d = '0;
    end else if (ref_run) begin
      ref_cnt_d = ref_cnt_q + 1'b1;
    end
    ref_pend_d = ref_pend_q;
    if (grant_ref) begin
      ref_pend_d = 1'b0;
    end else if (ref_expire) begin
      ref_pend_d = 1'b1;
    end
    missed_d = missed_q | (ref_expire & ref_pend_q);
  end

  // Port selection: port 0 first, then the round-robin pair.
  always_comb begin
    p1_wins    = p1_req && (!rr_q || !p2_req);
    grant_acc  = 1'b0;
    grant_port = 2'd0;
    sel_we     = p0_we;
    sel_addr   = p0_addr;
    sel_din    = p0_din;
    if (p0_req) begin
      grant_acc = 1'b1;
    end else if (p1_wins) begin
      grant_acc  = 1'b1;
      grant_port = 2'd1;
      sel_we     = p1_we;
      sel_addr   = p1_addr;
      sel_din    = p1_din;
    end else if (p2_req) begin
      grant_acc  = 1'b1;
      grant_port = 2'd2;
      sel_we     = p2_we;
      sel_addr   = p2_addr;
      sel_din    = p2_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      port_q       <= 2'd0;
      rr_q         <= 1'b0;
      ref_cnt_q    <= '0;
      ref_pend_q   <= 1'b0;
      missed_q     <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      sd_cs_q      <= 1'b0;
      sd_we_q      <= 1'b0;
      sd_addr_q    <= '0;
      sd_din_q     <= '0;
      sd_refresh_q <= 1'b0;
    end else begin
      ref_cnt_q    <= ref_cnt_d;
      ref_pend_q   <= ref_pend_d;
      missed_q     <= missed_d;
      ack_q        <= '0;
      sd_refresh_q <= 1'b0;
      if (!sd_ready) begin
        // Controller lost: abort the slot without ack, request stays pending.
        state_q   <= S_INIT;
        cnt_q     <= '0;
        sd_cs_q   <= 1'b0;
        sd_we_q   <= 1'b0;
        sd_addr_q <= '0;
        sd_din_q  <= '0;
      end else begin
        unique case (state_q)
          S_INIT: begin
            state_q <= S_GUARD;
            cnt_q   <= '0;
          end
          S_GUARD: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= S_IDLE;
          end
          S_IDLE: begin
            cnt_q <= '0;
            if (grant_ref) begin
              state_q      <= S_REFRESH;
              sd_refresh_q <= 1'b1;
            end else if (grant_acc) begin
              state_q   <= S_ACCESS;
              sd_cs_q   <= 1'b1;
              port_q    <= grant_port;
              sd_we_q   <= sel_we;
              sd_addr_q <= sel_addr;
              sd_din_q  <= sel_din;
              if (grant_port != 2'd0) rr_q <= (grant_port == 2'd1);
            end
          end
          S_ACCESS: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == T6) begin
              sd_cs_q <= 1'b0;
              ack_q   <= 3'b001 << port_q;
              if (!sd_we_q) rdata_q <= sd_dout;
            end
            if (cnt_q == LAST) state_q <= S_IDLE;
          end
          S_REFRESH: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= S_IDLE;
          end
          default: state_q <= S_INIT;
        endcase
      end
    end
  end

  assign p0_ack         = ack_q[0];
  assign p1_ack         = ack_q[1];
  assign p2_ack         = ack_q[2];
  assign rdata          = rdata_q;
  assign sd_cs          = sd_cs_q;
  assign sd_we          = sd_we_q;
  assign sd_addr        = sd_addr_q;
  assign sd_din         = sd_din_q;
  assign sd_refresh     = sd_refresh_q;
  assign missed_refresh = missed_q;

endmodule

// File: tb/tb_sdram8_arbiter.sv
// Bench for sdram8_arbiter: directed scenarios plus random traffic, every
// cycle compared against a slot-timeline reference model.
module tb_sdram8_arbiter;

  localparam int unsigned RC = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sd_ready = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [2:0]  ack;
  logic [22:0] addr [3];
  logic [7:0]  din [3];
  logic [7:0]  rdata, sd_din, sd_dout;
  logic [22:0] sd_addr;
  logic        sd_cs, sd_we, sd_refresh, missed_refresh;
  logic [7:0]  dout_t6 = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Reference model: integer slot timeline and expected outputs.
  bit        m_down = 1'b1, m_is_ref = 1'b0, m_pend = 1'b0, m_missed = 1'b0;
  bit        expire, counting;
  int        m_guard = 0, m_pos = -1, m_port = 0, m_tmr = 0, m_rr = 1, pick;
  logic      e_cs = 1'b0, e_ref = 1'b0, e_we = 1'b0;
  logic [2:0]  e_ack = '0;
  logic [7:0]  e_rdata = '0, e_din = '0;
  logic [22:0] e_addr = '0;

  sdram8_arbiter #(.REFRESH_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_din(din[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_din(din[1]),
    .p2_req(req[2]), .p2_we(we[2]), .p2_addr(addr[2]), .p2_din(din[2]),
    .p0_ack(ack[0]), .p1_ack(ack[1]), .p2_ack(ack[2]),
    .rdata(rdata), .sd_ready(sd_ready),
    .sd_cs(sd_cs), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
    .sd_dout(sd_dout), .sd_refresh(sd_refresh), .missed_refresh(missed_refresh)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) if (ack[k]) req[k] = 1'b0;
  endtask

  function automatic bit m_idle();
    return !m_down && m_guard == 0 && m_pos < 0;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_down = 1'b1; m_guard = 0; m_pos = -1; m_tmr = 0; m_pend = 1'b0;
      m_missed = 1'b0; m_rr = 1; e_cs = 1'b0; e_ref = 1'b0; e_ack = '0;
      e_rdata = '0; e_we = 1'b0; e_addr = '0; e_din = '0;
    end else begin
      counting = !m_down && m_guard == 0;
      expire   = counting && (m_tmr == int'(RC) - 1);
      if (counting) m_tmr = expire ? 0 : m_tmr + 1;
      e_ack = '0;
      e_ref = 1'b0;
      if (!sd_ready) begin
        if (expire) begin m_missed |= m_pend; m_pend = 1'b1; end
        m_down = 1'b1; m_guard = 0; m_pos = -1;
        e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
      end else if (m_down) begin
        m_down = 1'b0; m_guard = 8;
      end else if (m_guard > 0) begin
        m_guard--;
      end else if (m_pos < 0) begin
        if (m_pend || expire) begin
          m_missed |= expire && m_pend;
          m_pend = 1'b0; m_pos = 0; m_is_ref = 1'b1; e_ref = 1'b1;
        end else begin
          pick = -1;
          if (req[0]) pick = 0;
          else if (req[m_rr]) pick = m_rr;
          else if (req[3 - m_rr]) pick = 3 - m_rr;
          if (pick >= 0) begin
            m_pos = 0; m_is_ref = 1'b0; m_port = pick; e_cs = 1'b1;
            e_we = we[pick]; e_addr = addr[pick]; e_din = din[pick];
            if (pick != 0) m_rr = 3 - pick;
          end
        end
      end else begin
        if (expire) begin m_missed |= m_pend; m_pend = 1'b1; end
        if (m_pos == 7) m_pos = -1;
        else begin
          m_pos++;
          if (m_pos == 7 && !m_is_ref) begin
            e_cs = 1'b0;
            e_ack[m_port] = 1'b1;
            if (!e_we) e_rdata = sd_dout;
          end
        end
      end
    end
  end

  // Controller stand-in: data is only meaningful in t6.
  always @(negedge clk) sd_dout = (m_pos == 6) ? dout_t6 : 8'($urandom);

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sd_cs", 32'(sd_cs), 32'(e_cs));
      chk("sd_refresh", 32'(sd_refresh), 32'(e_ref));
      chk("ack", 32'(ack), 32'(e_ack));
      chk("rdata", 32'(rdata), 32'(e_rdata));
      chk("sd_bus", {sd_we, sd_addr, sd_din}, {e_we, e_addr, e_din});
      chk("missed", 32'(missed_refresh), 32'(m_missed));
    end
  end

  initial begin
    int n, cs_cnt, ack_cnt, drop_left;
    bit got, prev_cs;
    int order[$];
    int starts[$];
    for (int k = 0; k < 3; k++) begin addr[k] = '0; din[k] = '0; end
    drop_left = 0;

    repeat (2) step();
    chk_en = 1'b1;
    chk("rst_zero", 32'({sd_cs, sd_refresh, ack, missed_refresh, sd_we, rdata, sd_din}), 32'h0);
    chk("rst_addr", 32'(sd_addr), 32'h0);

    // Port 0 write pending as reset is released.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 23'h123456; din[0] = 8'hA5;
    reset_n = 1'b1;
    n = 0;
    while (!sd_cs && n < 40) begin step(); n++; end
    chk("first_grant_lat", 32'(n), 32'd10);
    chk("wr_bus", {sd_we, sd_addr, sd_din}, {1'b1, 23'h123456, 8'hA5});
    cs_cnt = 1; ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sd_cs) cs_cnt++;
      if (ack[0]) ack_cnt++;
    end
    chk("wr_cs_cycles", 32'(cs_cnt), 32'd7);
    chk("wr_ack_pulses", 32'(ack_cnt), 32'd1);

    // Port 0 read returning 0x3C.
    dout_t6 = 8'h3C;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 23'h00BEEF;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin step(); got = ack[0]; end
    chk("rd_ack_seen", 32'(got), 32'd1);
    chk("rd_data", 32'(rdata), 32'h3C);
    repeat (4) step();
    chk("rd_hold", 32'(rdata), 32'h3C);

    // Ports 1 and 2 continuously requesting.
    for (int k = 1; k < 3; k++) begin
      req[k] = 1'b1; we[k] = 1'($urandom); addr[k] = 23'($urandom); din[k] = 8'($urandom);
    end
    prev_cs = sd_cs;
    for (int i = 0; i < 100 && order.size() < 4; i++) begin
      step();
      if ((sd_cs && !prev_cs) || sd_refresh) starts.push_back(cyc);
      prev_cs = sd_cs;
      for (int k = 1; k < 3; k++) if (ack[k]) begin
        order.push_back(k);
        if (order.size() < 4) begin
          req[k] = 1'b1; we[k] = 1'($urandom); addr[k] = 23'($urandom); din[k] = 8'($urandom);
        end
      end
    end
    chk("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", 32'(order[i]), 32'((i % 2) ? 2 : 1));
    chk("rr_starts", 32'(starts.size() >= 4), 32'd1);
    for (int i = 1; i < starts.size() && i < 4; i++) chk("rr_spacing", 32'(starts[i] - starts[i-1]), 32'd9);
    for (int i = 0; i < 40 && req != 3'b000; i++) step();
    chk("rr_drained", 32'(req), 32'd0);

    // Refresh expiry in the same idle cycle as a port 0 request.
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      got = m_idle() && !m_pend && m_tmr == int'(RC) - 1;
    end
    chk("ref_align", 32'(got), 32'd1);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 23'h7A5A5A; dout_t6 = 8'h5E;
    step();
    chk("ref_first", 32'(sd_refresh), 32'd1);
    chk("ref_no_cs", 32'(sd_cs), 32'd0);
    step();
    chk("ref_pulse", 32'(sd_refresh), 32'd0);
    n = 2;
    while (!sd_cs && n < 30) begin step(); n++; end
    chk("ref_to_p0_gap", 32'(n - 1), 32'd9);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = ack[0]; end
    chk("ref_p0_ack", 32'(got), 32'd1);

    // Controller drops ready at t3 of a read.
    dout_t6 = 8'h77;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 23'h012345;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = m_pos == 3 && !m_is_ref && m_port == 0;
    end
    chk("drop_at_t3", 32'(got), 32'd1);
    sd_ready = 1'b0;
    step();
    chk("drop_cs", 32'(sd_cs), 32'd0);
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); if (ack[0]) ack_cnt++; end
    sd_ready = 1'b1;
    chk("drop_noack", 32'(ack_cnt), 32'd0);
    chk("drop_req_held", 32'(req[0]), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin step(); got = ack[0]; end
    chk("drop_served", 32'(got), 32'd1);
    chk("drop_rdata", 32'(rdata), 32'h77);

    // Random traffic with occasional controller resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) sd_ready = 1'b1;
      end else if ($urandom_range(399) == 0) begin
        sd_ready = 1'b0;
        drop_left = $urandom_range(6, 1);
      end
      for (int k = 0; k < 3; k++) begin
        if (!req[k] && $urandom_range((k == 0) ? 11 : 3) == 0) begin
          req[k] = 1'b1; we[k] = 1'($urandom); addr[k] = 23'($urandom); din[k] = 8'($urandom);
        end
      end
      dout_t6 = 8'($urandom);
    end
    sd_ready = 1'b1;
    repeat (2) step();
    chk("missed_final", 32'(missed_refresh), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
